// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder with a single registered output slot.
// Define CONV_ENC_TAIL_EN to append two zero-tail codewords per frame; otherwise frames are truncated.
module conv_enc_k3 #(
   parameter int unsigned FRAME_LEN = 8,
   parameter logic [2:0]  G0        = 3'b111,
   parameter logic [2:0]  G1        = 3'b101
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out,
   output logic       out_last,
   output logic [1:0] dbg_state_o
);
   localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   // Handshake: a word moves on a rising edge where valid and ready are both 1; valid never
   // waits on ready, and a stalled output word (out_valid & !out_ready) holds out/out_last.
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sr_q, sr_d;
   logic [1:0]    out_q, out_d;
   logic          vld_q, vld_d;
   logic          last_q, last_d;
   logic          en_q;
   logic          slot_free, accept, u;
   logic [2:0]    taps;
   logic [1:0]    cw;

   assign slot_free = ~vld_q | out_ready;
   assign in_ready  = en_q & slot_free & (state_q != TAIL);
   assign accept    = in_valid & in_ready;
   // Tail codewords encode u=0, which falls out of accept being low in TAIL.
   assign u         = accept & in_bit;
   assign taps      = {u, sr_q};
   assign cw        = {^(G1 & taps), ^(G0 & taps)};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      out_d   = out_q;
      vld_d   = vld_q;
      last_d  = last_q;
      if (out_ready) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
      end
      if (accept) begin
         out_d   = cw;
         vld_d   = 1'b1;
         last_d  = 1'b0;
         sr_d    = {u, sr_q[1]};
         cnt_d   = cnt_q + 1'b1;
         state_d = DATA;
         if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
`ifdef CONV_ENC_TAIL_EN
            state_d = TAIL;
`else
            state_d = IDLE;
            sr_d    = 2'b00;
            last_d  = 1'b1;
`endif
         end
      end
`ifdef CONV_ENC_TAIL_EN
      else if ((state_q == TAIL) && slot_free) begin
         out_d = cw;
         vld_d = 1'b1;
         sr_d  = {1'b0, sr_q[1]};
         // cnt_q[0] marks the second tail word; the trellis is forced home as it loads.
         if (cnt_q[0]) begin
            last_d  = 1'b1;
            sr_d    = 2'b00;
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            last_d = 1'b0;
            cnt_d  = cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= 2'b00;
         out_q   <= 2'b00;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         en_q    <= 1'b1;
      end
   end

   assign out         = out_q;
   assign out_valid   = vld_q;
   assign out_last    = last_q;
   assign dbg_state_o = state_q;

endmodule
